// File: rtl/itch_event_queue.sv
// First-word-fall-through queue of parsed ITCH records between the parser and a ready/valid consumer.
// Optional macro ITCH_QUEUE_DROP_COUNT_EN enables the saturating dropped-record counter.
module itch_event_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       parsed_valid,
    input  logic [3:0]                 parsed_type,
    input  logic [63:0]                order_ref,
    input  logic                       side,
    input  logic [31:0]                shares,
    input  logic [31:0]                price,
    input  logic [63:0]                new_order_ref,
    input  logic [47:0]                timestamp,
    input  logic [63:0]                misc_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [3:0]                 out_type,
    output logic [63:0]                out_order_ref,
    output logic                       out_side,
    output logic [31:0]                out_shares,
    output logic [31:0]                out_price,
    output logic [63:0]                out_new_order_ref,
    output logic [47:0]                out_timestamp,
    output logic [63:0]                out_misc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       clr_overflow,
    output logic [15:0]                drop_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = 309;

    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [RW-1:0] head;
    logic          push;
    logic          pop;
    logic          drop;

    assign out_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push      = parsed_valid && (!full || pop);
    assign drop      = parsed_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {parsed_type, order_ref, side, shares, price,
                            new_order_ref, timestamp, misc_data};
        end
    end

    assign head = mem[rd_ptr];
    assign {out_type, out_order_ref, out_side, out_shares, out_price,
            out_new_order_ref, out_timestamp, out_misc} = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef ITCH_QUEUE_DROP_COUNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

endmodule
